// File: rtl/fpu_operand_loader.sv
// Purpose: assembles fpu operands A and B from a byte stream, holds them stable, then captures the fpu result.
// Latency: result_valid rises HOLD_CYCLES edges after the edge that accepts byte 7.
// Backpressure: byte_ready is low while holding or presenting; the result is held until result_ready.
module fpu_operand_loader #(
    parameter int HOLD_CYCLES    = 40,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] op_A_out,
    output logic [31:0] op_B_out,
    input  logic [31:0] fpu_data_in,
    input  logic [3:0]  fpu_status_in,
    output logic [31:0] result_out,
    output logic [3:0]  result_status,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy,
    output logic        timeout_err
);
    // Timers are sized so their terminal count fits without wrapping.
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        HOLD    = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      byte_cnt;
    // Bytes 0..6 are staged here (byte 0 at the top); byte 7 goes straight
    // into op_B_out together with the staged bytes, so it is never stored.
    logic [55:0]     shadow;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   idle_cnt;
    logic            xfer;
    logic            last_byte;
    logic            hold_done;
    logic            idle_expire;

    assign byte_ready  = (state == IDLE) || (state == LOAD);
    assign busy        = (state != IDLE);
    assign xfer        = byte_valid && byte_ready;
    assign last_byte   = (state == LOAD) && xfer && (byte_cnt == 3'd7);
    assign hold_done   = (state == HOLD) && (hold_cnt == HOLD_LAST);
    // An accepted byte in the same cycle beats the timeout.
    assign idle_expire = (state == LOAD) && !xfer && (idle_cnt == IDLE_LAST);

    // State register.
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; unknown encodings fall back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = LOAD;
            LOAD: begin
                if (last_byte) begin
                    state_nxt = HOLD;
                end else if (idle_expire) begin
                    state_nxt = IDLE;
                end
            end
            HOLD:    if (hold_done) state_nxt = PRESENT;
            PRESENT: if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand assembly, settle timer, idle timer and result capture.
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            byte_cnt      <= '0;
            shadow        <= '0;
            hold_cnt      <= '0;
            idle_cnt      <= '0;
            op_A_out      <= '0;
            op_B_out      <= '0;
            result_out    <= '0;
            result_status <= '0;
            result_valid  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            timeout_err <= idle_expire;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        shadow   <= {48'd0, byte_in};
                        byte_cnt <= 3'd1;
                        idle_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        shadow   <= {shadow[47:0], byte_in};
                        byte_cnt <= byte_cnt + 3'd1;
                        idle_cnt <= '0;
                        if (byte_cnt == 3'd7) begin
                            op_A_out <= shadow[55:24];
                            op_B_out <= {shadow[23:0], byte_in};
                            shadow   <= '0;
                            hold_cnt <= '0;
                        end
                    end else if (idle_expire) begin
                        // Abandon the partial load; presented operands stay as they were.
                        byte_cnt <= '0;
                        shadow   <= '0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + HW'(1);
                    if (hold_done) begin
                        result_out    <= fpu_data_in;
                        result_status <= fpu_status_in;
                        result_valid  <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_operand_loader.sv
// Purpose: self-checking bench for fpu_operand_loader with a settling fpu model and a result scoreboard.
// Latency: checks result_valid arrives exactly 40 edges after byte 7 is accepted.
// Backpressure: stalls result_ready and drives byte_valid during the stall.
module tb_fpu_operand_loader;
    logic        clock100KHz = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] op_A_out;
    logic [31:0] op_B_out;
    logic [31:0] fpu_data_in;
    logic [3:0]  fpu_status_in;
    logic [31:0] result_out;
    logic [3:0]  result_status;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
    logic        timeout_err;

    fpu_operand_loader #(.HOLD_CYCLES(40), .TIMEOUT_CYCLES(1000)) dut (
        .clock100KHz   (clock100KHz),
        .reset         (reset),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .op_A_out      (op_A_out),
        .op_B_out      (op_B_out),
        .fpu_data_in   (fpu_data_in),
        .fpu_status_in (fpu_status_in),
        .result_out    (result_out),
        .result_status (result_status),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clock100KHz = ~clock100KHz;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int stab   = 0;
    int to_cnt = 0;
    int t7     = 0;
    logic [31:0] pa = '0;
    logic [31:0] pb = '0;
    logic [31:0] cur_a = '0;
    logic [31:0] cur_b = '0;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  s;
    } exp_t;
    exp_t sb[$];

    // Reference fpu: known answer for the 0.5/4.0 pair, otherwise a scramble.
    function automatic logic [31:0] fres(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F00_0000 && b == 32'h4080_0000) return 32'h4100_0000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h0101_0101;
    endfunction

    function automatic logic [3:0] fst(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F00_0000 && b == 32'h4080_0000) return 4'b0001;
        return a[3:0] ^ b[7:4];
    endfunction

    // The fpu output is garbage until operands have been stable for a while.
    assign fpu_data_in   = (stab >= 30) ? fres(op_A_out, op_B_out) : (32'hBAD0_0000 | 32'(stab));
    assign fpu_status_in = (stab >= 30) ? fst(op_A_out, op_B_out) : 4'hF;

    always @(posedge clock100KHz) begin
        cyc <= cyc + 1;
        if (op_A_out != pa || op_B_out != pb) stab <= 0;
        else if (stab < 100000) stab <= stab + 1;
        pa <= op_A_out;
        pb <= op_B_out;
    end

    always @(negedge clock100KHz) begin
        if (timeout_err) to_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clock100KHz);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 500) begin
            @(negedge clock100KHz);
            n++;
        end
        if (!byte_ready) chk("byte_ready_wait", 64'(byte_ready), 64'd1);
        @(negedge clock100KHz);
        byte_valid = 1'b0;
    endtask

    // gap_idx < 0: every byte after the first waits `gap` idle cycles; else only byte gap_idx.
    task automatic send_load(input logic [31:0] a, input logic [31:0] b, input int gap, input int gap_idx);
        logic [63:0] w;
        w = {a, b};
        for (int i = 0; i < 8; i++) begin
            send_byte(w[63-8*i -: 8], (i == 0) ? 0 : ((gap_idx < 0 || gap_idx == i) ? gap : 0));
            if (i == 6) begin
                chk("opA_before_b7", 64'(op_A_out), 64'(cur_a));
                chk("opB_before_b7", 64'(op_B_out), 64'(cur_b));
            end
        end
        t7 = cyc;
        chk("opA_on_b7", 64'(op_A_out), 64'(a));
        chk("opB_on_b7", 64'(op_B_out), 64'(b));
        chk("byte_ready_in_hold", 64'(byte_ready), 64'd0);
        cur_a = a;
        cur_b = b;
        sb.push_back({fres(a, b), fst(a, b)});
    endtask

    task automatic take_result(input int stall);
        int   n;
        exp_t e;
        n = 0;
        while (!result_valid && n < 200) begin
            @(negedge clock100KHz);
            n++;
        end
        chk("result_latency", 64'(cyc - t7), 64'd40);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 64'(sb.size()), 64'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("result_out", 64'(result_out), 64'(e.r));
        chk("result_status", 64'(result_status), 64'(e.s));
        byte_in    = 8'hAA;
        byte_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock100KHz);
            chk("stall_valid", 64'(result_valid), 64'd1);
            chk("stall_result", 64'(result_out), 64'(e.r));
            chk("stall_byte_ready", 64'(byte_ready), 64'd0);
        end
        result_ready = 1'b1;
        byte_valid   = 1'b0;
        @(negedge clock100KHz);
        result_ready = 1'b0;
        chk("valid_dropped", 64'(result_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_byte_ready", 64'(byte_ready), 64'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int hits;
        int tc;
        int rv_seen;
        reset        = 1'b1;
        byte_in      = '0;
        byte_valid   = 1'b0;
        result_ready = 1'b0;
        repeat (3) @(negedge clock100KHz);
        chk("rst_opA", 64'(op_A_out), 64'd0);
        chk("rst_opB", 64'(op_B_out), 64'd0);
        chk("rst_result", 64'(result_out), 64'd0);
        chk("rst_status", 64'(result_status), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_byte_ready", 64'(byte_ready), 64'd1);
        reset = 1'b0;
        @(negedge clock100KHz);

        // Back-to-back load, then a 10-cycle downstream stall.
        send_load(32'h3F00_0000, 32'h4080_0000, 0, -1);
        take_result(10);

        // Partial load abandoned by the idle timeout.
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        first = -1;
        hits  = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clock100KHz);
            if (timeout_err) begin
                hits++;
                if (first < 0) first = i;
            end
        end
        chk("timeout_cycle", 64'(first), 64'd1000);
        chk("timeout_pulses", 64'(hits), 64'd1);
        chk("timeout_busy", 64'(busy), 64'd0);
        chk("timeout_opA_kept", 64'(op_A_out), 64'(cur_a));
        chk("timeout_opB_kept", 64'(op_B_out), 64'(cur_b));
        send_load(32'h1234_5678, 32'h9ABC_DEF0, 0, -1);
        take_result(0);

        // Every byte arrives after 999 idle cycles: no timeout.
        tc = to_cnt;
        send_load(32'hCAFE_F00D, 32'h0123_4567, 999, -1);
        chk("slow_no_timeout", 64'(to_cnt), 64'(tc));
        take_result(2);

        // A byte on the would-be timeout edge wins.
        tc = to_cnt;
        send_load(32'h0BAD_BEEF, 32'h1357_9BDF, 999, 3);
        chk("edge_no_timeout", 64'(to_cnt), 64'(tc));
        take_result(1);

        // Reset in the middle of the hold window.
        send_load(32'hAAAA_5555, 32'h5555_AAAA, 0, -1);
        repeat (5) @(negedge clock100KHz);
        reset = 1'b1;
        @(negedge clock100KHz);
        reset = 1'b0;
        void'(sb.pop_front());
        cur_a = '0;
        cur_b = '0;
        chk("hrst_opA", 64'(op_A_out), 64'd0);
        chk("hrst_opB", 64'(op_B_out), 64'd0);
        chk("hrst_result", 64'(result_out), 64'd0);
        chk("hrst_valid", 64'(result_valid), 64'd0);
        chk("hrst_busy", 64'(busy), 64'd0);
        chk("hrst_byte_ready", 64'(byte_ready), 64'd1);
        rv_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock100KHz);
            if (result_valid) rv_seen++;
        end
        chk("hrst_no_result", 64'(rv_seen), 64'd0);
        send_load(32'h3F00_0000, 32'h4080_0000, 0, -1);
        take_result(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
